// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : prod_accum
//  Purpose  : Block accumulator for two unsigned product streams. Sums p_len
//             valid samples per block and hands each block result to a
//             one-deep valid/ready output register, dropping results that
//             cannot be delivered.
//  Revision : 1.0 - initial release
// ============================================================================
module prod_accum #(
  parameter int p_size  = 12,
  parameter int p_len   = 8,
  parameter int p_len_w = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*p_size-1:0]           i_data,
  input  logic [2*p_size-1:0]           i_data_2,
  input  logic                          i_dv,
  input  logic                          i_ready,
  output logic [2*p_size+p_len_w-1:0]   o_acc,
  output logic [2*p_size+p_len_w-1:0]   o_acc_2,
  output logic                          o_valid,
  output logic                          o_drop
);

  localparam int ACC_W = 2*p_size + p_len_w;
  localparam logic [p_len_w-1:0] C_LAST = p_len_w'(p_len - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [p_len_w-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_2_q, acc_2_d;
  logic [ACC_W-1:0]   sum_d, sum_2_d;
  logic               blk_end_d;
  state_t             state_q;
  logic [ACC_W-1:0]   res_q, res_2_q;
  logic               valid_q, drop_q;

  // Next-state of the sample counter and accumulators; never stalls on i_ready.
  always_comb begin
    blk_end_d = i_dv && (cnt_q == C_LAST);
    sum_d     = acc_q   + {{p_len_w{1'b0}}, i_data};
    sum_2_d   = acc_2_q + {{p_len_w{1'b0}}, i_data_2};
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_2_d   = acc_2_q;
    if (i_dv) begin
      if (blk_end_d) begin
        cnt_d   = '0;
        acc_d   = '0;
        acc_2_d = '0;
      end else begin
        cnt_d   = cnt_q + p_len_w'(1);
        acc_d   = sum_d;
        acc_2_d = sum_2_d;
      end
    end
  end

  // Accumulator and sample-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      acc_2_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      acc_2_q <= acc_2_d;
    end
  end

  // Output FSM: holds one block result, replaces it on a coincident handshake,
  // otherwise discards a new result while full and pulses o_drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      res_q   <= '0;
      res_2_q <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_EMPTY: begin
          if (blk_end_d) begin
            state_q <= S_FULL;
            valid_q <= 1'b1;
            res_q   <= sum_d;
            res_2_q <= sum_2_d;
          end
        end
        S_FULL: begin
          if (i_ready) begin
            if (blk_end_d) begin
              res_q   <= sum_d;
              res_2_q <= sum_2_d;
            end else begin
              state_q <= S_EMPTY;
              valid_q <= 1'b0;
            end
          end else if (blk_end_d) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_acc   = res_q;
  assign o_acc_2 = res_2_q;
  assign o_valid = valid_q;
  assign o_drop  = drop_q;

endmodule
`default_nettype wire

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter p_size, default 12: operand width of the upstream product stage; each input word is 2*p_size bits.
REQ-002 Parameter p_len, default 8: products summed per block; power of two, range 2..256.
REQ-003 Parameter p_len_w, default 3: log2(p_len); output width is 2*p_size+p_len_w (27 at defaults).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_data  in  2*p_size  first product word from the upstream stage, unsigned.
REQ-007 i_data_2  in  2*p_size  second product word from the upstream stage, unsigned.
REQ-008 i_dv  in  1  upstream data valid; one sample per high cycle; no backpressure to upstream.
REQ-009 o_acc  out  2*p_size+p_len_w  block sum of i_data.
REQ-010 o_acc_2  out  2*p_size+p_len_w  block sum of i_data_2.
REQ-011 o_valid  out  1  o_acc/o_acc_2 hold an unconsumed block result.
REQ-012 i_ready  in  1  downstream accepts the result; transfer occurs on o_valid&&i_ready.
REQ-013 o_drop  out  1  one-cycle pulse: a completed block was discarded.

Function
REQ-014 The accumulator path shall never stall; every i_dv=1 cycle shall be summed, independent of i_ready.
REQ-015 Internal accumulators acc and acc_2 are 2*p_size+p_len_w bits, zero-extended unsigned adds, no saturation; the width is exact, so overflow cannot occur.
REQ-016 Sample counter cnt is p_len_w bits, increments on i_dv, and wraps from p_len-1 to 0.
REQ-017 On i_dv with cnt<p_len-1: acc<=acc+i_data, acc_2<=acc_2+i_data_2.
REQ-018 On i_dv with cnt==p_len-1 (block end): completed sums acc+i_data and acc_2+i_data_2 are offered to the output register; acc and acc_2 clear to 0 in the same edge.
REQ-019 Output FSM has two states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-020 EMPTY + block end -> FULL; result loaded; o_valid rises the cycle after the last sample (latency 1).
REQ-021 FULL + i_ready + no block end -> EMPTY.
REQ-022 FULL + i_ready + block end -> stays FULL; new result loaded; o_valid stays 1.
REQ-023 FULL + !i_ready + block end -> stays FULL; o_acc/o_acc_2 unchanged; new result discarded; o_drop=1 next cycle.
REQ-024 o_acc/o_acc_2 shall be stable while o_valid=1 and i_ready=0, except as given in REQ-022.
REQ-025 o_drop shall be registered and high for exactly one cycle per discarded block.
REQ-026 i_data/i_data_2 are ignored when i_dv=0.

Reset
REQ-027 When rst=1 at a rising edge: cnt=0, acc=0, acc_2=0, state=EMPTY, o_valid=0, o_acc=0, o_acc_2=0, o_drop=0.
REQ-028 Reset overrides i_dv and i_ready in the same cycle; a partial block in progress is discarded.
REQ-029 The first sample after reset release starts a new block at cnt=0.

Verification
REQ-030 Basic: 8 back-to-back i_dv samples, i_data=k, i_data_2=2k, k=1..8, i_ready=1 -> one cycle after the 8th sample, o_valid=1, o_acc=36, o_acc_2=72, pulse lasts 1 cycle.
REQ-031 Max values: 8 samples, all inputs 24'hFFFFFF -> o_acc=o_acc_2=27'h7FFFFF8; no wrap.
REQ-032 Gapped input: 8 samples spread over 20 cycles with random i_dv gaps -> same sums as the contiguous case; o_valid rises 1 cycle after the 8th sample.
REQ-033 Backpressure drop: i_ready=0 through two completed blocks (sums 36, then 100) -> o_acc holds 36; o_drop pulses once, 1 cycle after the second block end; after i_ready=1, o_valid falls.
REQ-034 Coincident events: block end in the same cycle as an o_valid&&i_ready handshake -> o_valid stays 1, o_acc updates to the new sum, o_drop=0.
REQ-035 Reset mid-block: rst after 5 samples, then 8 samples of value 1 -> o_acc=8, proving the partial sum was cleared.
